// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state
// encodings, the divide iteration count and the divide-by-zero quotient.
package hilo_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  localparam int          DIV_CYCLES = 32;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

  // Signed ops are everything except the two unsigned forms.
  function automatic logic op_is_signed(input op_e op);
    return (op != OP_MULTU) && (op != OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the HI/LO unit.
interface hilo_muldiv_unit_if;
  import hilo_muldiv_unit_pkg::*;

  logic        start;
  op_e         op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit_div_iter_unit.sv
// Unsigned restoring divider datapath: one quotient bit per step strobe.
// Operands arrive already made non-negative by the owner FSM.
module div_iter_unit #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quot_q, quot_d;
  logic [W-1:0] dvsr_q, dvsr_d;
  logic [W:0]   shifted;
  logic [W:0]   trial;

  // Shift the next dividend bit into the remainder and trial-subtract;
  // keep the difference only when it did not borrow.
  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    shifted = {rem_q, quot_q[W-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (load_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      if (!trial[W]) begin
        rem_d  = trial[W-1:0];
        quot_d = {quot_q[W-2:0], 1'b1};
      end else begin
        rem_d  = shifted[W-1:0];
        quot_d = {quot_q[W-2:0], 1'b0};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the EX stage: single-cycle multiply family, 33-cycle
// restoring divide, and direct MTHI/MTLO writes. Hi/Lo feed the writeback
// mux straight from their flops.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DIV_ITERS = DIV_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hilo_muldiv_unit_if.slave   bus_io
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_neg_q, a_neg_d;   // dividend negative (signed only)
  logic               q_neg_q, q_neg_d;   // operand signs differ (signed only)
  logic               b_zero_q, b_zero_d;

  logic               div_load, div_step;
  logic [31:0]        a_abs, b_abs;
  logic [31:0]        quot, rem;
  logic               in_sgn, mul_sgn;
  logic signed [65:0] prod_full;
  logic [63:0]        prod;

  // Divider sees magnitudes; signs are restored in FIX.
  assign in_sgn = op_is_signed(bus_io.op);
  assign a_abs  = (in_sgn && bus_io.a[31]) ? -bus_io.a : bus_io.a;
  assign b_abs  = (in_sgn && bus_io.b[31]) ? -bus_io.b : bus_io.b;

  // 33x33 signed multiply covers both signed and unsigned forms by
  // choosing the extension bit; only the low 64 bits are architectural.
  assign mul_sgn   = (op_q != OP_MULTU);
  assign prod_full = $signed({mul_sgn & a_q[31], a_q}) * $signed({mul_sgn & b_q[31], b_q});
  assign prod      = prod_full[63:0];

  div_iter_unit #(.W(32)) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  // Next-state and HI/LO write decisions.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    a_neg_d  = a_neg_q;
    q_neg_d  = q_neg_q;
    b_zero_d = b_zero_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.start) begin
          case (bus_io.op)
            OP_MTHI: begin
              hi_d   = bus_io.a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus_io.a;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              op_d     = bus_io.op;
              a_d      = bus_io.a;
              a_neg_d  = in_sgn & bus_io.a[31];
              q_neg_d  = in_sgn & (bus_io.a[31] ^ bus_io.b[31]);
              b_zero_d = (bus_io.b == 32'd0);
              cnt_d    = '0;
              div_load = 1'b1;
              state_d  = ST_DIV;
            end
            default: begin
              op_d    = bus_io.op;
              a_d     = bus_io.a;
              b_d     = bus_io.b;
              state_d = ST_MUL;
            end
          endcase
        end
      end
      ST_MUL: begin
        case (op_q)
          OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
          OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
          default: {hi_d, lo_d} = prod;
        endcase
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (b_zero_q) begin
          lo_d = DIV0_QUOT;
          hi_d = a_q;
        end else begin
          lo_d = q_neg_q ? -quot : quot;
          hi_d = a_neg_q ? -rem : rem;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and architectural state; reset aborts any op in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      a_neg_q  <= a_neg_d;
      q_neg_q  <= q_neg_d;
      b_zero_q <= b_zero_d;
    end
  end

  assign bus_io.busy = (state_q != ST_IDLE);
  assign bus_io.done = done_q;
  assign bus_io.hi   = hi_q;
  assign bus_io.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scenario bench for hilo_muldiv_unit with a queue of expected HI/LO pairs.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  hilo_muldiv_unit_if bus();

  hilo_muldiv_unit dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Advance until Done is seen or the budget runs out.
  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (3) tick();
    e = '{hi: 32'h0, lo: 32'h0};
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_chk++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL reset_hi got %h want %h", bus.hi, e.hi); end
    n_chk++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL reset_lo got %h want %h", bus.lo, e.lo); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    exp_t e;
    int cyc;
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy got %b want 1", bus.busy); end
    wait_done(5, cyc);
    n_chk++; if (cyc !== 1) begin n_fail++; $display("FAIL mult_latency got %0d want 1", cyc); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_done got %b want 0", bus.busy); end
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL mult_hilo got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    tick();
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
    sb.push_back('{hi: 32'h0000_0002, lo: 32'hFFFF_FFFA});
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_done(5, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 1) begin n_fail++; $display("FAIL multu_hilo got %h_%h cyc %0d want %h_%h cyc 1", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    tick();
  endtask

  task automatic test_madd_msub();
    exp_t e;
    int cyc;
    issue(OP_MTHI, 32'h0, 32'hDEAD);
    n_chk++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 32'h0) begin n_fail++; $display("FAIL mthi got done %b busy %b hi %h want 1 0 0", bus.done, bus.busy, bus.hi); end
    issue(OP_MTLO, 32'd5, 32'hBEEF);
    n_chk++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.lo !== 32'd5) begin n_fail++; $display("FAIL mtlo got done %b busy %b lo %h want 1 0 5", bus.done, bus.busy, bus.lo); end
    sb.push_back('{hi: 32'h0, lo: 32'h0000_000B});
    issue(OP_MADD, 32'd2, 32'd3);
    wait_done(5, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 1) begin n_fail++; $display("FAIL madd got %h_%h cyc %0d want %h_%h cyc 1", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    tick();
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFB});
    issue(OP_MSUB, 32'd4, 32'd4);
    wait_done(5, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 1) begin n_fail++; $display("FAIL msub got %h_%h cyc %0d want %h_%h cyc 1", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    tick();
  endtask

  task automatic test_div();
    exp_t e;
    int cyc;
    int busy_cyc;
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_cyc = 0;
    cyc = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) busy_cyc++;
      tick();
      cyc++;
    end
    n_chk++; if (cyc !== 33 || busy_cyc !== 33) begin n_fail++; $display("FAIL div_latency got cyc %0d busy %0d want 33 33", cyc, busy_cyc); end
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL div_neg got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    tick();
    sb.push_back('{hi: 32'd2, lo: 32'd14});
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(60, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 33) begin n_fail++; $display("FAIL divu got %h_%h cyc %0d want %h_%h cyc 33", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    tick();
  endtask

  task automatic test_div_corners();
    exp_t e;
    int cyc;
    sb.push_back('{hi: 32'h0, lo: 32'h8000_0000});
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(60, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 33) begin n_fail++; $display("FAIL div_ovf got %h_%h cyc %0d want %h_%h cyc 33", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    tick();
    sb.push_back('{hi: 32'h0000_1234, lo: 32'hFFFF_FFFF});
    issue(OP_DIVU, 32'h0000_1234, 32'h0);
    wait_done(60, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 33) begin n_fail++; $display("FAIL div_zero got %h_%h cyc %0d want %h_%h cyc 33", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    tick();
    sb.push_back('{hi: 32'hFFFF_FFF9, lo: 32'hFFFF_FFFF});
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0);
    wait_done(60, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL div_zero_signed got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    int n_done;
    sb.push_back('{hi: 32'd1, lo: 32'd333});
    issue(OP_DIVU, 32'd1000, 32'd3);
    cyc = 0;
    while (!bus.done && cyc < 60) begin
      bus.start = (cyc == 5 || cyc == 20);
      bus.op    = OP_MULT;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 33) begin n_fail++; $display("FAIL ignore_start got %h_%h cyc %0d want %h_%h cyc 33", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    // Issue in the Done cycle.
    sb.push_back('{hi: 32'h0, lo: 32'd42});
    issue(OP_MULTU, 32'd6, 32'd7);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy %b want 1", bus.busy); end
    wait_done(5, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 1) begin n_fail++; $display("FAIL b2b_mult got %h_%h cyc %0d want %h_%h cyc 1", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    n_chk++; if (n_done !== 0 || bus.lo !== 32'd42) begin n_fail++; $display("FAIL no_queued_op got %0d dones lo %h want 0 dones lo 0000002a", n_done, bus.lo); end
  endtask

  task automatic test_abort();
    exp_t e;
    int cyc;
    int n_done;
    issue(OP_DIVU, 32'd5000, 32'd7);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_fail++; $display("FAIL abort_reset got busy %b hi %h lo %h want 0 0 0", bus.busy, bus.hi, bus.lo); end
    tick();
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    n_chk++; if (n_done !== 0 || bus.lo !== 32'h0) begin n_fail++; $display("FAIL abort_no_done got %0d dones lo %h want 0 dones lo 0", n_done, bus.lo); end
    sb.push_back('{hi: 32'h0, lo: 32'd15});
    issue(OP_MULTU, 32'd3, 32'd5);
    wait_done(5, cyc);
    e = sb.pop_front();
    n_chk++; if ({bus.hi, bus.lo} !== {e.hi, e.lo} || cyc !== 1) begin n_fail++; $display("FAIL abort_recover got %h_%h cyc %0d want %h_%h cyc 1", bus.hi, bus.lo, cyc, e.hi, e.lo); end
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_mult();
    test_madd_msub();
    test_div();
    test_div_corners();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide unit owning the architectural HI and LO registers of the MIPS datapath. Executes MULT, MULTU, MADD, MSUB, DIV, DIVU, MTHI and MTLO under a start/busy/done handshake. Sits in the EX stage, upstream of the 32-bit 5-to-1 writeback select mux, and drives that mux's HI and LO data inputs for MFHI/MFLO.

## Interface
- DIV_CYCLES, 32, number of restoring-division iterations; fixed at 32 for this datapath.
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle request; sampled only in IDLE
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- A  input  32  rs operand; dividend for DIV/DIVU, source for MTHI/MTLO
- B  input  32  rt operand; divisor for DIV/DIVU
- Busy  output  1  high while a multiply or divide is in flight
- Done  output  1  one-cycle pulse when HI/LO hold a new result
- Hi  output  32  HI register, driven straight from the flop
- Lo  output  32  LO register, driven straight from the flop

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, Start=1:
  - MTHI/MTLO: Hi (resp. Lo) <= A at the sampling edge; next state IDLE; Done=1 for the following cycle.
  - MULT/MULTU/MADD/MSUB: capture A, B and the signedness; go to MUL.
  - DIV/DIVU: capture |A|, |B| (raw values for DIVU), both sign bits and B==0; counter <= 0; go to DIV.
- MUL: compute the 64-bit product, signed for MULT/MADD/MSUB and unsigned for MULTU.
  - MULT/MULTU: {Hi,Lo} <= product.
  - MADD: {Hi,Lo} <= {Hi,Lo} + product.
  - MSUB: {Hi,Lo} <= {Hi,Lo} - product.
  - All arithmetic is modulo 2^64. Go to IDLE with Done=1.
- DIV: one restoring step per cycle (shift remainder left, trial-subtract divisor, set quotient bit). Counter increments; go to FIX after iteration DIV_CYCLES.
- FIX: write the result, go to IDLE with Done=1.
  - Lo <= quotient, negated if the operand signs differ (signed ops only).
  - Hi <= remainder, negated if the dividend is negative (signed ops only).
  - Quotient truncates toward zero.
- Divide by zero (B==0): same latency; Lo <= 0xFFFFFFFF, Hi <= A.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): Lo <= 0x80000000, Hi <= 0.
- Start while not IDLE is ignored, with no queuing; Op/A/B are don't-care outside the sampling edge.
- Hi/Lo change only on the write edges defined above; they hold their value at all other times.

## Timing
- Reset asserted: state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0, applied immediately (asynchronous). Reset mid-operation aborts the op, and no Done is produced.
- Edge E0 samples Start in IDLE.
- MTHI/MTLO: register written at E0; Done=1 during the E0→E1 cycle; Busy stays 0.
- Multiply family: Busy=1 during E0→E1; Hi/Lo written at E1; Done=1 during E1→E2; Busy=0 from E1. Latency is 1 cycle.
- Divide: Busy=1 from E0 to E33; iterations at E1..E32; result written at E33 (FIX); Done=1 during E33→E34. Latency is 33 cycles.
- Done is never high for more than one cycle.
- Start is accepted in the same cycle that Done is high (back-to-back issue).
- The downstream writeback mux sees the new Hi/Lo in the cycle where Done=1.

## Structure
- Shared package: Op encodings (OP_MULT..OP_MSUB), state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX), the DIV_CYCLES default, and the divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module, div_iter_unit. It holds the remainder/quotient/divisor registers and the iteration step, and is controlled by load/step strobes from the top FSM.
- The top level owns the FSM, the multiplier, the sign handling, and the Hi/Lo flops.

## Test plan
- Reset, then MULT with A=0xFFFFFFFE (-2), B=3 → one cycle later Done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; MULTU with the same operands → Hi=0x00000002, Lo=0xFFFFFFFA.
- MTHI A=0, MTLO A=5, then MADD A=2, B=3 → Lo=0x0000000B, Hi=0; then MSUB A=4, B=4 → Lo=0xFFFFFFFB, Hi=0xFFFFFFFF.
- DIV A=-7 (0xFFFFFFF9), B=2 → Busy for 33 cycles, Done on cycle 34, Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=100, B=7 → Lo=14, Hi=2.
- DIV A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0; DIVU A=0x1234, B=0 → Lo=0xFFFFFFFF, Hi=0x1234 with normal latency.
- Start pulses with Op=MULT issued during a DIV → ignored, exactly one Done, and the DIV result is intact; a new Start in the Done cycle is accepted.
- Reset asserted at iteration 10 of a DIV → Busy=0, Hi=Lo=0 immediately, no Done; the next MULTU 3×5 gives Lo=15.
